dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the target side of the processor's memory stage.
- Accepts one 8-byte read or write request at a time over a valid/ready handshake.
- Models a configurable access latency, then returns read data and an error flag over a second valid/ready handshake.
- Replaces the zero-latency combinational RAM, so the memory stage can be stalled against a realistic slave.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one 8-byte read/write at a time, fixed latency, valid/ready both sides.
// Optional DMEM_ALIGN_CHECK_EN: accesses with addr[2:0] != 0 also fault.
module dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);
  localparam int unsigned AW      = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);
  localparam logic [64:0] MaxAddr = 65'(DEPTH_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q;
  logic [63:0]   addr_q, wdata_q;
  logic [63:0]   rdata_q, rdata_d;
  logic          error_q, error_d;

  logic [7:0]    mem [DEPTH_BYTES];

  logic          accept, access, mem_we;
  logic          acc_write, acc_fault;
  logic [63:0]   acc_addr, acc_wdata, acc_rdata;
  logic [AW-1:0] acc_idx;

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

  // With LATENCY=1 the access happens on the acceptance edge, so use the live request.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == StIdle) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    acc_fault = ({1'b0, acc_addr} + 65'd7) > MaxAddr;
`ifdef DMEM_ALIGN_CHECK_EN
    if (acc_addr[2:0] != 3'd0) acc_fault = 1'b1;
`endif
    acc_idx   = acc_addr[AW-1:0];
    acc_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      acc_rdata[8*i +: 8] = mem[acc_idx + AW'(i)];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    access  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = CntInit;
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          error_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (access) begin
      error_d = acc_fault;
      rdata_d = (acc_fault || acc_write) ? '0 : acc_rdata;
    end
  end

  assign mem_we = access && acc_write && !acc_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        mem[acc_idx + AW'(i)] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus reset, backpressure and LATENCY=1 sequences.
module tb_dmem_responder;
  localparam int Lat = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_error;
  logic [63:0] rsp_rdata;

  logic        l1_req_valid = 1'b0, l1_req_write = 1'b0;
  logic [63:0] l1_req_addr = '0, l1_req_wdata = '0;
  logic        l1_req_ready, l1_rsp_valid, l1_rsp_error;
  logic [63:0] l1_rsp_rdata;

  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(Lat)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_write(l1_req_write), .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
    .rsp_valid(l1_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(l1_rsp_rdata),
    .rsp_error(l1_rsp_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] rd;
    logic        er;
    int          hold;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input string tag);
    int          cyc;
    logic [63:0] erd;
    logic        eer;
    erd = v.rd;
    eer = v.er;
`ifdef DMEM_ALIGN_CHECK_EN
    if (v.a[2:0] != 3'd0) begin
      erd = '0;
      eer = 1'b1;
    end
`endif
    @(negedge clk);
    req_valid = 1'b1;
    req_write = v.w;
    req_addr  = v.a;
    req_wdata = v.d;
    cyc = 0;
    while (!req_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 'x;
    req_wdata = 'x;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(Lat));
    chk({tag, " rdata"}, rsp_rdata, erd);
    chk({tag, " error"}, 64'(rsp_error), 64'(eer));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, " hold rdata"}, rsp_rdata, erd);
      chk({tag, " hold error"}, 64'(rsp_error), 64'(eer));
      chk({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " done valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, " done rdata"}, rsp_rdata, 64'd0);
    chk({tag, " idle req_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 0};
    vecs[1]  = '{1'b0, 64'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 5};
    vecs[2]  = '{1'b1, 64'h18, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 0};
    vecs[3]  = '{1'b0, 64'h11, 64'h0, 64'h8801_2345_6789_ABCD, 1'b0, 0};
    vecs[4]  = '{1'b0, 64'h12, 64'h0, 64'h7788_0123_4567_89AB, 1'b0, 0};
    vecs[5]  = '{1'b1, 64'h3F8, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0, 0};
    vecs[6]  = '{1'b0, 64'h3F8, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0};
    vecs[7]  = '{1'b0, 64'h3F9, 64'h0, 64'h0, 1'b1, 0};
    vecs[8]  = '{1'b1, 64'h0, 64'h5555_AAAA_1234_5678, 64'h0, 1'b0, 0};
    vecs[9]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0};
    vecs[10] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 64'h0, 1'b1, 0};
    vecs[11] = '{1'b0, 64'h0, 64'h0, 64'h5555_AAAA_1234_5678, 1'b0, 0};
    vecs[12] = '{1'b0, 64'h3F8, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0};
    vecs[13] = '{1'b1, 64'h20, 64'h1357_9BDF_0246_8ACE, 64'h0, 1'b0, 0};

    #1;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rdata", rsp_rdata, 64'd0);
    chk("reset error", 64'(rsp_error), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while BUSY must abort the pending write.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
    chk("rstbusy req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstbusy busy req_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rstbusy rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstbusy req_ready", 64'(req_ready), 64'd0);
    chk("rstbusy rdata", rsp_rdata, 64'd0);
    chk("rstbusy error", 64'(rsp_error), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstbusy release req_ready", 64'(req_ready), 64'd1);
    do_req('{1'b0, 64'h20, 64'h0, 64'h1357_9BDF_0246_8ACE, 1'b0, 0}, "rstbusy readback");

    // LATENCY=1 with rsp_ready tied high: accept on every other edge.
    @(negedge clk);
    l1_req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("l1 k%0d req_ready", k), 64'(l1_req_ready), 64'((k % 2) == 0));
      chk($sformatf("l1 k%0d rsp_valid", k), 64'(l1_rsp_valid), 64'((k % 2) == 1));
      if (k == 0) begin
        l1_req_write = 1'b1;
        l1_req_addr  = 64'h8;
        l1_req_wdata = 64'hFEDC_BA98_7654_3210;
      end else if (k == 2) begin
        l1_req_write = 1'b0;
        l1_req_addr  = 64'h8;
      end else if (k == 4) begin
        l1_req_write = 1'b0;
        l1_req_addr  = 64'h3F9;
      end
      if (k == 1) chk("l1 write rdata", l1_rsp_rdata, 64'd0);
      if (k == 3) begin
        chk("l1 read rdata", l1_rsp_rdata, 64'hFEDC_BA98_7654_3210);
        chk("l1 read error", 64'(l1_rsp_error), 64'd0);
      end
      if (k == 5) begin
        chk("l1 fault rdata", l1_rsp_rdata, 64'd0);
        chk("l1 fault error", 64'(l1_rsp_error), 64'd1);
      end
      @(negedge clk);
    end
    l1_req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
